// File: rtl/prf_pkg.sv
// rtl/prf_pkg.sv - shared widths, priority select and zero-entry constant for the physical register file
package prf_pkg;

  // Widest port group the priority selector handles.
  localparam int MAX_PORTS = 16;

  // Entry that reads as zero and stays ready when ZERO_REG is set.
  localparam int ZERO_ADDR = 0;

  // Width of a flattened port bundle: one slice of 'width' bits per port.
  function automatic int bundle_width(input int ports, input int width);
    return ports * width;
  endfunction

  // Index of the highest set bit in hits; 0 when none is set, so callers
  // must qualify the result with |hits.
  function automatic int prio_sel(input logic [MAX_PORTS-1:0] hits);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (hits[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/prf_entry.sv
// rtl/prf_entry.sv - one register file entry: data word plus ready (scoreboard) bit
//   clk, rst       : clock, synchronous active-high reset
//   wr_hit_i       : per-write-port hit on this entry
//   alloc_hit_i    : per-alloc-port hit on this entry
//   write_data_i   : all write ports' data, port k in slice k
//   data_o, ready_o: stored data and ready bit
module prf_entry
  import prf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WRITE  = 4,
  parameter int NUM_ALLOC  = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_WRITE-1:0]                         wr_hit_i,
  input  logic [NUM_ALLOC-1:0]                         alloc_hit_i,
  input  logic [bundle_width(NUM_WRITE, DATA_WIDTH)-1:0] write_data_i,
  output logic [DATA_WIDTH-1:0]                        data_o,
  output logic                                         ready_o
);

  int                    sel;
  logic [DATA_WIDTH-1:0] wdata;

  // Highest-index hitting port supplies the data.
  always_comb begin
    sel   = prio_sel(MAX_PORTS'(wr_hit_i));
    wdata = '0;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (k == sel) wdata = write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      ready_o <= 1'b1;
    end else begin
      if (|wr_hit_i) data_o <= wdata;
      // A same-cycle alloc belongs to a newer producer, so it beats the write.
      if (|alloc_hit_i)   ready_o <= 1'b0;
      else if (|wr_hit_i) ready_o <= 1'b1;
    end
  end

endmodule

// File: rtl/prf_multiport.sv
// rtl/prf_multiport.sv - multi-port physical register file with ready bits, bypass and optional zero entry
//   clk, rst                  : clock, synchronous active-high reset
//   write_en/addr/data_i      : NUM_WRITE writeback ports, port k in slice k
//   alloc_en/addr_i           : NUM_ALLOC ports clearing the ready bit of an entry
//   read_en/addr_i            : NUM_READ operand read ports
//   read_data_o, read_ready_o : per-read-port data and ready, zero when the port is disabled
module prf_multiport
  import prf_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int NUM_READ     = 4,
  parameter int NUM_WRITE    = 4,
  parameter int NUM_ALLOC    = 2,
  parameter int BYPASS       = 1,
  parameter int READ_LATENCY = 0,
  parameter int ZERO_REG     = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_WRITE-1:0]                          write_en_i,
  input  logic [bundle_width(NUM_WRITE, ADDR_WIDTH)-1:0] write_addr_i,
  input  logic [bundle_width(NUM_WRITE, DATA_WIDTH)-1:0] write_data_i,
  input  logic [NUM_ALLOC-1:0]                          alloc_en_i,
  input  logic [bundle_width(NUM_ALLOC, ADDR_WIDTH)-1:0] alloc_addr_i,
  input  logic [NUM_READ-1:0]                           read_en_i,
  input  logic [bundle_width(NUM_READ, ADDR_WIDTH)-1:0]  read_addr_i,
  output logic [bundle_width(NUM_READ, DATA_WIDTH)-1:0]  read_data_o,
  output logic [NUM_READ-1:0]                           read_ready_o
);

  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]      ent_ready;

  // Storage: decode write/alloc hits per entry. The zero entry never sees a
  // hit, so it keeps its reset value (data 0, ready 1) forever.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [NUM_WRITE-1:0] wr_hit;
    logic [NUM_ALLOC-1:0] al_hit;

    always_comb begin
      wr_hit = '0;
      al_hit = '0;
      for (int k = 0; k < NUM_WRITE; k++) begin
        wr_hit[k] = write_en_i[k] &&
                    (write_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e));
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
        al_hit[a] = alloc_en_i[a] &&
                    (alloc_addr_i[a*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e));
      end
      if (ZERO_REG != 0 && e == ZERO_ADDR) begin
        wr_hit = '0;
        al_hit = '0;
      end
    end

    prf_entry #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WRITE  (NUM_WRITE),
      .NUM_ALLOC  (NUM_ALLOC)
    ) u_entry (
      .clk          (clk),
      .rst          (rst),
      .wr_hit_i     (wr_hit),
      .alloc_hit_i  (al_hit),
      .write_data_i (write_data_i),
      .data_o       (ent_data[e]),
      .ready_o      (ent_ready[e])
    );
  end

  // Read ports: stored value, overridden by bypass, then by the zero entry,
  // then by the port enable.
  for (genvar r = 0; r < NUM_READ; r++) begin : g_read
    logic [ADDR_WIDTH-1:0] raddr;
    logic [NUM_WRITE-1:0]  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rrdy;
    int                    byp_sel;

    always_comb begin
      raddr   = read_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
      byp_hit = '0;
      for (int k = 0; k < NUM_WRITE; k++) begin
        byp_hit[k] = write_en_i[k] &&
                     (write_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == raddr);
      end
      byp_sel  = prio_sel(MAX_PORTS'(byp_hit));
      byp_data = '0;
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (k == byp_sel) byp_data = write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end

      rdata = ent_data[raddr];
      rrdy  = ent_ready[raddr];
      // Bypass deliberately ignores a same-cycle alloc: the forwarded value
      // is the completed result, which is ready.
      if (BYPASS != 0 && |byp_hit) begin
        rdata = byp_data;
        rrdy  = 1'b1;
      end
      if (ZERO_REG != 0 && raddr == ADDR_WIDTH'(ZERO_ADDR)) begin
        rdata = '0;
        rrdy  = 1'b1;
      end
      if (!read_en_i[r]) begin
        rdata = '0;
        rrdy  = 1'b0;
      end
    end

    if (READ_LATENCY == 0) begin : g_comb
      assign read_data_o[r*DATA_WIDTH +: DATA_WIDTH] = rdata;
      assign read_ready_o[r]                         = rrdy;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          read_data_o[r*DATA_WIDTH +: DATA_WIDTH] <= '0;
          read_ready_o[r]                         <= 1'b0;
        end else begin
          read_data_o[r*DATA_WIDTH +: DATA_WIDTH] <= rdata;
          read_ready_o[r]                         <= rrdy;
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_multiport.sv
// tb/tb_prf_multiport.sv - directed and scoreboard checks of prf_multiport in three configurations
module tb_prf_multiport;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 4;
  localparam int NW = 4;
  localparam int NA = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NW-1:0]    write_en;
  logic [NW*AW-1:0] write_addr;
  logic [NW*DW-1:0] write_data;
  logic [NA-1:0]    alloc_en;
  logic [NA*AW-1:0] alloc_addr;
  logic [NR-1:0]    read_en;
  logic [NR*AW-1:0] read_addr;

  logic [NR*DW-1:0] rd_a, rd_b, rd_r;
  logic [NR-1:0]    rr_a, rr_b, rr_r;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [64];
  logic          rdy [64];
  logic [DW-1:0] exp_d [NR];
  logic          exp_r [NR];

  always #5 clk = ~clk;

  // a: bypass, combinational; b: no bypass, combinational; r: bypass, registered
  prf_multiport #(.BYPASS(1), .READ_LATENCY(0)) dut_a (
    .clk(clk), .rst(rst), .write_en_i(write_en), .write_addr_i(write_addr),
    .write_data_i(write_data), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .read_en_i(read_en), .read_addr_i(read_addr), .read_data_o(rd_a), .read_ready_o(rr_a));

  prf_multiport #(.BYPASS(0), .READ_LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .write_en_i(write_en), .write_addr_i(write_addr),
    .write_data_i(write_data), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .read_en_i(read_en), .read_addr_i(read_addr), .read_data_o(rd_b), .read_ready_o(rr_b));

  prf_multiport #(.BYPASS(1), .READ_LATENCY(1)) dut_r (
    .clk(clk), .rst(rst), .write_en_i(write_en), .write_addr_i(write_addr),
    .write_data_i(write_data), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .read_en_i(read_en), .read_addr_i(read_addr), .read_data_o(rd_r), .read_ready_o(rr_r));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dsl(input logic [NR*DW-1:0] v, input int r);
    return v[r*DW +: DW];
  endfunction

  task automatic idle();
    write_en = '0; alloc_en = '0; read_en = '0;
    write_addr = '0; write_data = '0; alloc_addr = '0; read_addr = '0;
  endtask

  task automatic wr(input int k, input int a, input logic [DW-1:0] d);
    write_en[k] = 1'b1;
    write_addr[k*AW +: AW] = AW'(a);
    write_data[k*DW +: DW] = d;
  endtask

  task automatic al(input int k, input int a);
    alloc_en[k] = 1'b1;
    alloc_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic rd(input int r, input int a);
    read_en[r] = 1'b1;
    read_addr[r*AW +: AW] = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference read for the current inputs against the model state.
  task automatic model_read(input bit byp);
    for (int r = 0; r < NR; r++) begin
      int a;
      a = int'(read_addr[r*AW +: AW]);
      exp_d[r] = mem[a];
      exp_r[r] = rdy[a];
      if (byp) begin
        for (int k = 0; k < NW; k++) begin
          if (write_en[k] && int'(write_addr[k*AW +: AW]) == a) begin
            exp_d[r] = write_data[k*DW +: DW];
            exp_r[r] = 1'b1;
          end
        end
      end
      if (a == 0) begin
        exp_d[r] = '0;
        exp_r[r] = 1'b1;
      end
      if (!read_en[r]) begin
        exp_d[r] = '0;
        exp_r[r] = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < NW; k++) begin
      if (write_en[k] && write_addr[k*AW +: AW] != '0) begin
        mem[int'(write_addr[k*AW +: AW])] = write_data[k*DW +: DW];
        rdy[int'(write_addr[k*AW +: AW])] = 1'b1;
      end
    end
    for (int j = 0; j < NA; j++) begin
      if (alloc_en[j] && alloc_addr[j*AW +: AW] != '0) rdy[int'(alloc_addr[j*AW +: AW])] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      rdy[i] = 1'b1;
    end
  endtask

  initial begin
    logic [DW-1:0] sav_d [NR];
    logic          sav_r [NR];

    // Reset; registered outputs must read 0 during reset even with reads enabled.
    rst = 1'b1;
    idle();
    for (int r = 0; r < NR; r++) rd(r, 5);
    tick();
    tick();
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("rst_reg_data_p%0d", r), dsl(rd_r, r), 32'h0);
      chk($sformatf("rst_reg_rdy_p%0d", r), 32'(rr_r[r]), 32'h0);
    end
    rst = 1'b0;
    #1;
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("post_rst_data_p%0d", r), dsl(rd_a, r), 32'h0);
      chk($sformatf("post_rst_rdy_p%0d", r), 32'(rr_a[r]), 32'h1);
      chk($sformatf("post_rst_nb_rdy_p%0d", r), 32'(rr_b[r]), 32'h1);
    end
    tick();
    chk("post_rst_reg_rdy", 32'(rr_r[0]), 32'h1);

    // Alloc 7, then read it: not ready.
    idle(); al(0, 7); tick();
    idle(); rd(0, 7); #1;
    chk("alloc7_rdy", 32'(rr_a[0]), 32'h0);
    chk("alloc7_nb_rdy", 32'(rr_b[0]), 32'h0);

    // Write 7 while reading it: bypass vs. no bypass.
    wr(1, 7, 32'hDEADBEEF); #1;
    chk("byp7_data", dsl(rd_a, 0), 32'hDEADBEEF);
    chk("byp7_rdy", 32'(rr_a[0]), 32'h1);
    chk("nobyp7_data", dsl(rd_b, 0), 32'h0);
    chk("nobyp7_rdy", 32'(rr_b[0]), 32'h0);
    tick();
    chk("reg_byp7_data", dsl(rd_r, 0), 32'hDEADBEEF);
    chk("reg_byp7_rdy", 32'(rr_r[0]), 32'h1);
    idle(); rd(0, 7); #1;
    chk("nobyp7_next_data", dsl(rd_b, 0), 32'hDEADBEEF);
    chk("nobyp7_next_rdy", 32'(rr_b[0]), 32'h1);

    // Two ports write 9: highest index wins.
    idle(); wr(0, 9, 32'h11); wr(3, 9, 32'h33); tick();
    idle(); rd(1, 9); #1;
    chk("dup9_data", dsl(rd_a, 1), 32'h33);
    chk("dup9_rdy", 32'(rr_a[1]), 32'h1);

    // Alloc and write 12 together: data lands, ready ends 0; bypass ignores alloc.
    idle(); al(1, 12); wr(2, 12, 32'h55); rd(2, 12); #1;
    chk("aw12_byp_data", dsl(rd_a, 2), 32'h55);
    chk("aw12_byp_rdy", 32'(rr_a[2]), 32'h1);
    tick();
    idle(); rd(2, 12); #1;
    chk("aw12_data", dsl(rd_a, 2), 32'h55);
    chk("aw12_rdy", 32'(rr_a[2]), 32'h0);
    chk("aw12_nb_rdy", 32'(rr_b[2]), 32'h0);

    // Entry 0 ignores writes, allocs and bypass; disabled port reads 0/0.
    idle(); wr(0, 0, 32'hFFFF); al(0, 0); rd(2, 0); #1;
    chk("zero_byp_data", dsl(rd_a, 2), 32'h0);
    chk("zero_byp_rdy", 32'(rr_a[2]), 32'h1);
    tick();
    idle(); rd(2, 0); read_addr[3*AW +: AW] = AW'(9); #1;
    chk("zero_data", dsl(rd_a, 2), 32'h0);
    chk("zero_rdy", 32'(rr_a[2]), 32'h1);
    chk("zero_nb_data", dsl(rd_b, 2), 32'h0);
    chk("dis_data", dsl(rd_a, 3), 32'h0);
    chk("dis_rdy", 32'(rr_a[3]), 32'h0);
    tick();
    chk("zero_reg_rdy", 32'(rr_r[2]), 32'h1);
    chk("dis_reg_data", dsl(rd_r, 3), 32'h0);
    chk("dis_reg_rdy", 32'(rr_r[3]), 32'h0);

    // Random traffic against the scoreboard, starting from a clean reset.
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    for (int c = 0; c < 150; c++) begin
      write_en = NW'($urandom);
      alloc_en = NA'($urandom);
      read_en  = NR'($urandom | $urandom);
      for (int k = 0; k < NW; k++) begin
        write_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
        write_data[k*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NA; j++) alloc_addr[j*AW +: AW] = AW'($urandom_range(0, 15));
      for (int r = 0; r < NR; r++) read_addr[r*AW +: AW] = AW'($urandom_range(0, 15));
      #1;
      model_read(1'b0);
      for (int r = 0; r < NR; r++) begin
        chk($sformatf("rnd%0d_nb_data_p%0d", c, r), dsl(rd_b, r), exp_d[r]);
        chk($sformatf("rnd%0d_nb_rdy_p%0d", c, r), 32'(rr_b[r]), 32'(exp_r[r]));
      end
      model_read(1'b1);
      for (int r = 0; r < NR; r++) begin
        chk($sformatf("rnd%0d_data_p%0d", c, r), dsl(rd_a, r), exp_d[r]);
        chk($sformatf("rnd%0d_rdy_p%0d", c, r), 32'(rr_a[r]), 32'(exp_r[r]));
        sav_d[r] = exp_d[r];
        sav_r[r] = exp_r[r];
      end
      tick();
      for (int r = 0; r < NR; r++) begin
        chk($sformatf("rnd%0d_reg_data_p%0d", c, r), dsl(rd_r, r), sav_d[r]);
        chk($sformatf("rnd%0d_reg_rdy_p%0d", c, r), 32'(rr_r[r]), 32'(sav_r[r]));
      end
      model_update();
    end

    // Reset mid-stream with writes and allocs active: everything back to 0/ready.
    write_en = '1;
    alloc_en = '1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      idle(); rd(a % NR, a); #1;
      chk($sformatf("mid_rst_data_a%0d", a), dsl(rd_a, a % NR), 32'h0);
      chk($sformatf("mid_rst_rdy_a%0d", a), 32'(rr_a[a % NR]), 32'h1);
    end
    tick();
    chk("mid_rst_reg_data", dsl(rd_r, 15 % NR), 32'h0);
    chk("mid_rst_reg_rdy", 32'(rr_r[15 % NR]), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
